// File: rtl/gcd_job_sequencer.sv
// Feeder/collector for an external stein_gcd core: buffers operand pairs in a
// small FIFO, runs one job at a time, and presents each result with its operands.
module gcd_job_sequencer #(
  parameter int DEPTH         = 4,
  parameter int RST_CYCLES    = 1,
  parameter int SETTLE_CYCLES = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic [7:0] core_a,
  output logic [7:0] core_b,
  output logic       core_reset,
  input  logic [7:0] core_res,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_a,
  output logic [7:0] out_b,
  output logic [7:0] out_res,
  output logic       busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PW   = AW + 1;
  localparam int CMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    HOLD
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [7:0]      memA_q [DEPTH];
  logic [7:0]      memB_q [DEPTH];
  logic [7:0]      coreA_q, coreB_q;
  logic            coreReset_q;
  logic            outValid_q;
  logic [7:0]      outA_q, outB_q, outRes_q;
  logic            empty, full, push, pop;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty    = (wrPtr_q == rdPtr_q);
  assign full     = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign in_ready = !full && !reset;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == IDLE) && !empty;
  assign wrPtr_d  = wrPtr_q + PW'(push);
  assign rdPtr_d  = rdPtr_q + PW'(pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      memA_q[wrPtr_q[AW-1:0]] <= in_a;
      memB_q[wrPtr_q[AW-1:0]] <= in_b;
    end
  end

  // Job sequencing: pop -> hold core in reset -> let it settle -> capture result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      coreA_q     <= '0;
      coreB_q     <= '0;
      coreReset_q <= 1'b1;
      outValid_q  <= 1'b0;
      outA_q      <= '0;
      outB_q      <= '0;
      outRes_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          coreReset_q <= 1'b0;
          if (pop) begin
            coreA_q     <= memA_q[rdPtr_q[AW-1:0]];
            coreB_q     <= memB_q[rdPtr_q[AW-1:0]];
            coreReset_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          if (cnt_q == RST_LAST) begin
            coreReset_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= SETTLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            outRes_q   <= core_res;
            outA_q     <= coreA_q;
            outB_q     <= coreB_q;
            outValid_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_a     = coreA_q;
  assign core_b     = coreB_q;
  assign core_reset = coreReset_q;
  assign out_valid  = outValid_q;
  assign out_a      = outA_q;
  assign out_b      = outB_q;
  assign out_res    = outRes_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Scoreboard bench for gcd_job_sequencer with a behavioural stand-in for the
// stein_gcd core whose result is only correct after the full settle time.
module tb_gcd_job_sequencer;

  localparam int DEPTH         = 4;
  localparam int RST_CYCLES    = 1;
  localparam int SETTLE_CYCLES = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [7:0] core_a, core_b, core_res;
  logic       core_reset;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_a, out_b, out_res;
  logic       busy;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  gcd_job_sequencer #(
    .DEPTH(DEPTH), .RST_CYCLES(RST_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .core_a(core_a), .core_b(core_b), .core_reset(core_reset), .core_res(core_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_res(out_res), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  // Core stand-in: gcd of magnitudes, reported as 8'hEE until the operands
  // have been out of reset for SETTLE_CYCLES-1 edges.
  function automatic logic [7:0] gcdRef(input logic [6:0] x, input logic [6:0] y);
    logic [7:0] p, q, t;
    p = {1'b0, x};
    q = {1'b0, y};
    for (int i = 0; i < 20 && q != 0; i++) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  logic [7:0] latA = '0;
  logic [7:0] latB = '0;
  int         lowCnt = 0;

  always @(posedge clk) begin
    if (core_reset) begin
      latA   <= core_a;
      latB   <= core_b;
      lowCnt <= 0;
    end else if (lowCnt < 100) begin
      lowCnt <= lowCnt + 1;
    end
  end

  assign core_res = (lowCnt >= SETTLE_CYCLES - 1) ? gcdRef(latA[6:0], latB[6:0]) : 8'hEE;

  task automatic checkOutput(input string name, input logic [23:0] actual, input logic [23:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Offer one pair; the expected result is queued when the transfer is certain.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] res);
    bit done;
    exp_t e;
    done = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
    end
    if (done) begin
      e.a = a;
      e.b = b;
      e.res = res;
      expQ.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL pushTimeout: in_ready got 0 want 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 800 && expQ.size() != 0; i++) @(negedge clk);
    checkOutput("drainRemaining", 24'(expQ.size()), 24'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic waitOutValid();
    bit seen;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checkOutput("outValidSeen", 24'(seen), 24'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every output handshake, latency and HOLD stability.
  initial begin
    int         loadCycle;
    bit         crPrev, ovPrev, holdValid;
    logic [23:0] holdVals;
    exp_t       e;
    loadCycle = 0;
    crPrev = 1'b1;
    ovPrev = 1'b0;
    holdValid = 1'b0;
    holdVals = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        holdValid = 1'b0;
        ovPrev    = 1'b0;
      end else begin
        if (core_reset && !crPrev && busy) loadCycle = cycle;
        if (out_valid && !ovPrev)
          checkOutput("latency", 24'(cycle - loadCycle), 24'(RST_CYCLES + SETTLE_CYCLES));
        if (out_valid && !out_ready) begin
          if (holdValid) checkOutput("holdStable", {out_a, out_b, out_res}, holdVals);
          holdValid = 1'b1;
          holdVals  = {out_a, out_b, out_res};
        end else begin
          holdValid = 1'b0;
        end
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedResult: got res %0h want none", out_res);
          end else begin
            e = expQ.pop_front();
            checkOutput("outA", 24'(out_a), 24'(e.a));
            checkOutput("outB", 24'(out_b), 24'(e.b));
            checkOutput("outRes", 24'(out_res), 24'(e.res));
          end
        end
        ovPrev = out_valid;
      end
      crPrev = core_reset;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sawValid;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInReady", 24'(in_ready), 24'd0);
    checkOutput("rstCoreReset", 24'(core_reset), 24'd1);
    checkOutput("rstBusy", 24'(busy), 24'd0);
    checkOutput("rstOutValid", 24'(out_valid), 24'd0);
    checkOutput("rstCoreA", 24'({core_a, core_b}), 24'd0);
    checkOutput("rstOutRes", 24'({out_a, out_b, out_res}), 24'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("postRstInReady", 24'(in_ready), 24'd1);
    checkOutput("postRstBusy", 24'(busy), 24'd0);
    @(negedge clk);
    checkOutput("idleCoreReset", 24'(core_reset), 24'd0);
    @(posedge clk);
    #1;

    // T1 single job
    $display("[TB] T1 single job");
    out_ready = 1'b1;
    applyStimulus(8'h0A, 8'h04, 8'h02);
    waitDrain();

    // T2 back-to-back, signed operands pass through untouched
    $display("[TB] T2 back-to-back");
    applyStimulus(8'hB6, 8'h2D, 8'h09);
    applyStimulus(8'h3F, 8'h9C, 8'h07);
    applyStimulus(8'h04, 8'h09, 8'h01);
    waitDrain();

    // T3 backpressure: one in flight plus DEPTH buffered
    $display("[TB] T3 backpressure");
    out_ready = 1'b0;
    applyStimulus(8'h0C, 8'h08, 8'h04);
    applyStimulus(8'h15, 8'h0E, 8'h07);
    applyStimulus(8'h1E, 8'h12, 8'h06);
    applyStimulus(8'h81, 8'h05, 8'h01);
    applyStimulus(8'h64, 8'h4B, 8'h19);
    @(negedge clk);
    checkOutput("fullInReady", 24'(in_ready), 24'd0);
    waitOutValid();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("stillFullInReady", 24'(in_ready), 24'd0);
    out_ready = 1'b1;
    waitDrain();

    // T4 zero operands
    $display("[TB] T4 zero operands");
    applyStimulus(8'h00, 8'h04, 8'h04);
    applyStimulus(8'h00, 8'h00, 8'h00);
    waitDrain();

    // T5 reset during SETTLE with pairs queued
    $display("[TB] T5 reset mid-job");
    applyStimulus(8'h10, 8'h18, 8'h08);
    applyStimulus(8'h24, 8'h1B, 8'h09);
    applyStimulus(8'h09, 8'h06, 8'h03);
    for (int i = 0; i < 50 && !(busy && !core_reset); i++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    expQ.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t5InReady", 24'(in_ready), 24'd1);
    checkOutput("t5Busy", 24'(busy), 24'd0);
    checkOutput("t5OutValid", 24'(out_valid), 24'd0);
    sawValid = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid || busy) sawValid++;
    end
    checkOutput("t5NoJobAfterReset", 24'(sawValid), 24'd0);
    @(posedge clk);
    #1;
    applyStimulus(8'h00, 8'h02, 8'h02);
    waitDrain();

    // T6 push and pop in the same cycle at three entries
    $display("[TB] T6 simultaneous push/pop");
    out_ready = 1'b0;
    applyStimulus(8'h12, 8'h08, 8'h02);
    applyStimulus(8'h33, 8'h11, 8'h11);
    applyStimulus(8'h2A, 8'h0E, 8'h0E);
    applyStimulus(8'h19, 8'h0F, 8'h05);
    waitOutValid();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(8'h48, 8'h30, 8'h18);
    @(negedge clk);
    checkOutput("count3InReady", 24'(in_ready), 24'd1);
    @(posedge clk);
    #1;
    applyStimulus(8'h0D, 8'h27, 8'h0D);
    @(negedge clk);
    checkOutput("count4InReady", 24'(in_ready), 24'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDrain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
